// File: rtl/datapath_pkg.sv
// datapath_pkg: shared encodings, control bundle and condition evaluation for the multicycle datapath.
package datapath_pkg;
    typedef enum logic [3:0] {ALU_ADD, ALU_SUB, ALU_CMP, ALU_AND, ALU_OR, ALU_XOR, ALU_MOV} alu_op_t;
    typedef enum logic [1:0] {SHIFT_LSH, SHIFT_ASH, SHIFT_ROT, SHIFT_NONE} shift_op_t;
    typedef enum logic [2:0] {BUS_OPND, BUS_MEM, BUS_ALU, BUS_SHIFT, BUS_PC} bus_sel_t;
    typedef enum logic [1:0] {PC_INC, PC_JUMP, PC_BRANCH, PC_HOLD} pc_mode_t;
    typedef enum logic [3:0] {COND_EQ, COND_NE, COND_CS, COND_CC, COND_HI, COND_LS, COND_GT, COND_LE,
                              COND_FS, COND_FC, COND_LO, COND_HS, COND_LT, COND_GE, COND_UC, COND_NV} cond_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;
    localparam int FLAG_C = 0;
    localparam int FLAG_L = 1;
    localparam int FLAG_F = 2;
    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 4;
    localparam int NFLAGS = 5;
    typedef struct packed {
        logic [3:0] aluOp;
        logic [1:0] shiftOp;
        logic [2:0] busSel;
        logic       immSel;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic       flagWe;
        logic [1:0] pcMode;
        logic [3:0] cond;
    } ctl_t;
    // Conditions come in true/inverted pairs; cond[0] inverts, code 7 pair is always/never.
    function automatic logic condTrue(input logic [3:0] cond, input logic [NFLAGS-1:0] f);
        logic [7:0] p;
        p = {1'b1, !f[FLAG_N] && !f[FLAG_Z], !f[FLAG_L] && !f[FLAG_Z], f[FLAG_F],
             f[FLAG_N], f[FLAG_L], f[FLAG_C], f[FLAG_Z]};
        return p[cond[3:1]] ^ cond[0];
    endfunction
endpackage

// File: rtl/multicycle_datapath_if.sv
// multicycle_datapath_if: decoder control bundle plus unified-memory request/ready handshake.
interface multicycle_datapath_if #(parameter int WIDTH = 16, parameter int REGBITS = 4);
    logic               ctl_valid, ctl_ready;
    logic [3:0]         ctl_alu_op;
    logic [1:0]         ctl_shift_op;
    logic [2:0]         ctl_bus_sel;
    logic               ctl_imm_sel, ctl_reg_write, ctl_mem_read, ctl_mem_write, ctl_flag_we;
    logic [1:0]         ctl_pc_mode;
    logic [3:0]         ctl_cond;
    logic [WIDTH-1:0]   ctl_imm;
    logic [REGBITS-1:0] ctl_ra, ctl_rb;
    logic               mem_req, mem_we, mem_ready;
    logic [WIDTH-1:0]   mem_addr, mem_wdata, mem_rdata;
    modport master (
        input  ctl_valid, ctl_alu_op, ctl_shift_op, ctl_bus_sel, ctl_imm_sel, ctl_reg_write,
               ctl_mem_read, ctl_mem_write, ctl_flag_we, ctl_pc_mode, ctl_cond, ctl_imm, ctl_ra, ctl_rb,
               mem_rdata, mem_ready,
        output ctl_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
    modport slave (
        output ctl_valid, ctl_alu_op, ctl_shift_op, ctl_bus_sel, ctl_imm_sel, ctl_reg_write,
               ctl_mem_read, ctl_mem_write, ctl_flag_we, ctl_pc_mode, ctl_cond, ctl_imm, ctl_ra, ctl_rb,
               mem_rdata, mem_ready,
        input  ctl_ready, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dp_alu_shift.sv
// dp_alu_shift: combinational ALU, signed-amount shifter and CR16-style flag generation.
module dp_alu_shift
    import datapath_pkg::*;
#(parameter int WIDTH = 16)
(
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [3:0]        aluOp,
    input  logic [1:0]        shiftOp,
    output logic [WIDTH-1:0]  aluRes,
    output logic [WIDTH-1:0]  shiftRes,
    output logic [NFLAGS-1:0] flags,
    output logic              flagsValid
);
    localparam int SB = $clog2(WIDTH) + 1;
    localparam int M = WIDTH - 1;
    localparam logic [SB-1:0] WB = SB'(WIDTH);
    logic [WIDTH:0] sum, diff;
    logic [SB-1:0] amt, mag;
    logic [WIDTH-1:0] sra;
    logic subLike;
    assign sum = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};
    assign subLike = aluOp == ALU_SUB || aluOp == ALU_CMP;
    assign amt = b[SB-1:0];
    assign mag = amt[SB-1] ? -amt : amt;
    assign sra = $signed(a) >>> mag;
    // a is the destination operand, so CMP's L/N mean "dest below source" (unsigned/signed).
    always_comb begin
        aluRes = '0;
        flags = '0;
        flagsValid = 1'b1;
        case (aluOp)
            ALU_ADD: begin
                aluRes = sum[M:0];
                flags[FLAG_C] = sum[WIDTH];
                flags[FLAG_F] = a[M] == b[M] && sum[M] != a[M];
            end
            ALU_SUB, ALU_CMP: begin
                aluRes = diff[M:0];
                flags[FLAG_C] = diff[WIDTH];
                flags[FLAG_L] = diff[WIDTH];
                flags[FLAG_F] = a[M] != b[M] && diff[M] != a[M];
            end
            ALU_AND: aluRes = a & b;
            ALU_OR:  aluRes = a | b;
            ALU_XOR: aluRes = a ^ b;
            ALU_MOV: aluRes = b;
            default: flagsValid = 1'b0;
        endcase
        flags[FLAG_Z] = aluRes == '0;
        flags[FLAG_N] = subLike ? $signed(a) < $signed(b) : aluRes[M];
    end
    always_comb
        shiftRes = shiftOp == SHIFT_NONE ? a :
                   shiftOp == SHIFT_ROT ? (amt[SB-1] ? (a >> mag) | (a << (WB - mag)) : (a << mag) | (a >> (WB - mag))) :
                   !amt[SB-1] ? a << mag :
                   shiftOp == SHIFT_ASH ? sra : a >> mag;
endmodule

// File: rtl/multicycle_datapath.sv
// multicycle_datapath: one-in-flight IDLE/EXEC/MEM/WB datapath with wait-stated memory handshake.
// DATAPATH_PERF_CNT_EN adds retired_cnt/stall_cnt performance counters.
module multicycle_datapath
    import datapath_pkg::*;
#(parameter int WIDTH = 16, parameter int REGBITS = 4)
(
    input  logic                 clk,
    input  logic                 reset,
    multicycle_datapath_if.master bus,
    output logic [WIDTH-1:0]     pc,
    output logic [WIDTH-1:0]     bus_out
`ifdef DATAPATH_PERF_CNT_EN
    ,
    output logic [31:0]          retired_cnt,
    output logic [31:0]          stall_cnt
`endif
);
    state_t state, nextState;
    ctl_t ctl;
    logic [WIDTH-1:0] imm, raVal, rbVal, opnd, aluRes, shiftRes, aluQ, shiftQ, memQ, busVal, pcNext, nextSeq;
    logic [REGBITS-1:0] rb;
    logic [NFLAGS-1:0] flags, aluFlags;
    logic flagsValid;
    logic [WIDTH-1:0] regs [2**REGBITS];
    assign opnd = ctl.immSel ? imm : raVal;
    assign nextSeq = pc + WIDTH'(1);
    dp_alu_shift #(.WIDTH(WIDTH)) alu (
        .a(rbVal), .b(opnd), .aluOp(ctl.aluOp), .shiftOp(ctl.shiftOp),
        .aluRes(aluRes), .shiftRes(shiftRes), .flags(aluFlags), .flagsValid(flagsValid)
    );
    always_ff @(posedge clk)
        state <= reset ? S_IDLE : nextState;
    always_comb
        nextState = state == S_IDLE ? (bus.ctl_valid ? S_EXEC : S_IDLE) :
                    state == S_EXEC ? (ctl.memRead || ctl.memWrite ? S_MEM : S_WB) :
                    state == S_MEM ? (bus.mem_ready ? S_WB : S_MEM) : S_IDLE;
    always_comb begin
        bus.ctl_ready = state == S_IDLE;
        bus.mem_req = state == S_MEM;
        bus.mem_we = state == S_MEM && ctl.memWrite;
        bus.mem_addr = raVal;
        bus.mem_wdata = rbVal;
    end
    // BUS_PC publishes the return address so a jump-and-link can use it.
    always_comb begin
        busVal = ctl.busSel == BUS_MEM ? memQ : ctl.busSel == BUS_ALU ? aluQ :
                 ctl.busSel == BUS_SHIFT ? shiftQ : ctl.busSel == BUS_PC ? nextSeq : opnd;
        pcNext = ctl.pcMode == PC_HOLD ? pc :
                 ctl.pcMode == PC_INC || !condTrue(ctl.cond, flags) ? nextSeq :
                 ctl.pcMode == PC_JUMP ? opnd : pc + imm;
    end
    // Operands are captured at accept, so a same-op write to rb never disturbs its own read.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= '0;
            flags <= '0;
            bus_out <= '0;
            for (int i = 0; i < 2**REGBITS; i++) regs[i] <= '0;
        end else begin
            if (state == S_IDLE && bus.ctl_valid) begin
                ctl <= '{aluOp: bus.ctl_alu_op, shiftOp: bus.ctl_shift_op, busSel: bus.ctl_bus_sel,
                         immSel: bus.ctl_imm_sel, regWrite: bus.ctl_reg_write, memRead: bus.ctl_mem_read,
                         memWrite: bus.ctl_mem_write, flagWe: bus.ctl_flag_we, pcMode: bus.ctl_pc_mode,
                         cond: bus.ctl_cond};
                imm <= bus.ctl_imm;
                rb <= bus.ctl_rb;
                raVal <= regs[bus.ctl_ra];
                rbVal <= regs[bus.ctl_rb];
            end
            if (state == S_EXEC) begin
                aluQ <= aluRes;
                shiftQ <= shiftRes;
                if (ctl.flagWe && flagsValid) flags <= aluFlags;
            end
            if (state == S_MEM && bus.mem_ready && !ctl.memWrite) memQ <= bus.mem_rdata;
            if (state == S_WB) begin
                if (ctl.regWrite) begin
                    regs[rb] <= busVal;
                    bus_out <= busVal;
                end
                pc <= pcNext;
            end
        end
    end
`ifdef DATAPATH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        retired_cnt <= reset ? '0 : retired_cnt + 32'(state == S_WB);
        stall_cnt <= reset ? '0 : stall_cnt + 32'(state == S_MEM && !bus.mem_ready);
    end
`endif
endmodule
